// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered carry resolve
// one result bit per clock, LSB first, behind valid/ready handshakes.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c;
    logic               r_carry_out;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c_nxt;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Full-adder cell on the current LSBs of the shift registers
    assign w_s     = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Subtraction enters as a + ~b with the +1 supplied through the initial carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh      <= a;
            r_b_sh      <= sub ? ~b : b;
            r_c         <= sub;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_sum  <= {w_s, r_sum[WIDTH-1:1]};
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_c    <= w_c_nxt;
            if (w_last) begin
                r_cnt       <= '0;
                r_carry_out <= w_c_nxt;
                r_overflow  <= r_c ^ w_c_nxt;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, handshake and
// reset corner cases, then random ops against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                  output logic [W-1:0] es, output logic eco, output logic eov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (ms) begin
            ur  = ua - ub;
            eco = (ua >= ub);
            sr  = sa - sb;
        end else begin
            ur  = ua + ub;
            eco = (ur > 255);
            sr  = sa + sb;
        end
        es  = W'(ur);
        eov = (sr > 127) || (sr < -128);
    endfunction

    // One full transaction; inputs are scrambled during BUSY/DONE to prove they are ignored
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input int stall, input logic [W-1:0] es, input logic eco, input logic eov,
                          input string tag);
        int waited;
        int lat;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " in_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        sub = ts;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(W));
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carry_out"}, 32'(carry_out), 32'(eco));
        check({tag, " overflow"}, 32'(overflow), 32'(eov));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check({tag, " stall_sum"}, 32'(sum), 32'(es));
            check({tag, " stall_flags"}, {30'd0, carry_out, overflow}, {30'd0, eco, eov});
            check({tag, " stall_hs"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " back_to_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
        check({tag, " held_sum"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rs, eco, eov;

        vecs[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
        vecs[1] = '{8'd127, 8'd1,   1'b0, 8'h80,  1'b0, 1'b1};
        vecs[2] = '{8'd5,   8'd3,   1'b1, 8'd2,   1'b1, 1'b0};
        vecs[3] = '{8'd3,   8'd5,   1'b1, 8'hFE,  1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'd1,   1'b1, 8'h7F,  1'b1, 1'b1};
        vecs[5] = '{8'hFF,  8'd1,   1'b0, 8'h00,  1'b1, 1'b0};
        vecs[6] = '{8'd0,   8'd0,   1'b1, 8'h00,  1'b1, 1'b0};
        vecs[7] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", {30'd0, carry_out, overflow}, 32'd0);
        check("reset_hs", {30'd0, out_valid, in_ready}, 32'b01);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready outside DONE must be ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_out_ready", {30'd0, out_valid, in_ready}, 32'b01);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, (i == 0) ? 5 : 0,
                   vecs[i].es, vecs[i].eco, vecs[i].eov, $sformatf("vec%0d", i));
        end

        // Reset on the 3rd BUSY cycle discards the op immediately
        in_valid = 1'b1;
        a = 8'd77;
        b = 8'd99;
        sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midbusy_reset_sum", 32'(sum), 32'd0);
        check("midbusy_reset_hs", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd10, 8'd20, 1'b0, 1, 8'd30, 1'b0, 1'b0, "post_reset");

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, es, eco, eov);
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), es, eco, eov, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
